// File: rtl/ps2_pkg.sv
// Shared PS/2 transmit definitions: frame constants, FSM states and frame builder.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam logic [7:0]  BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } ps2_state_e;

  // Bit 0 goes on the wire first: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ascii_to_scancode.sv
// Combinational ASCII to PS/2 set-2 make-code table; mirrors the receive-side decoder.
module ascii_to_scancode (
  input  logic [7:0] ascii,
  output logic [7:0] scancode,
  output logic       hit
);

  logic [7:0] upper;

  // Lower-case letters share the upper-case key codes.
  always_comb begin
    upper = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A) begin
      upper = ascii - 8'h20;
    end
  end

  always_comb begin
    scancode = 8'h00;
    hit      = 1'b1;
    case (upper)
      8'h41: scancode = 8'h1C;  // A
      8'h42: scancode = 8'h32;
      8'h43: scancode = 8'h21;
      8'h44: scancode = 8'h23;
      8'h45: scancode = 8'h24;
      8'h46: scancode = 8'h2B;
      8'h47: scancode = 8'h34;
      8'h48: scancode = 8'h33;
      8'h49: scancode = 8'h43;
      8'h4A: scancode = 8'h3B;
      8'h4B: scancode = 8'h42;
      8'h4C: scancode = 8'h4B;
      8'h4D: scancode = 8'h3A;
      8'h4E: scancode = 8'h31;
      8'h4F: scancode = 8'h44;
      8'h50: scancode = 8'h4D;
      8'h51: scancode = 8'h15;
      8'h52: scancode = 8'h2D;
      8'h53: scancode = 8'h1B;
      8'h54: scancode = 8'h2C;
      8'h55: scancode = 8'h3C;
      8'h56: scancode = 8'h2A;
      8'h57: scancode = 8'h1D;
      8'h58: scancode = 8'h22;
      8'h59: scancode = 8'h35;
      8'h5A: scancode = 8'h1A;  // Z
      8'h30: scancode = 8'h45;  // 0
      8'h31: scancode = 8'h16;
      8'h32: scancode = 8'h1E;
      8'h33: scancode = 8'h26;
      8'h34: scancode = 8'h25;
      8'h35: scancode = 8'h2E;
      8'h36: scancode = 8'h36;
      8'h37: scancode = 8'h3D;
      8'h38: scancode = 8'h3E;
      8'h39: scancode = 8'h46;  // 9
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard emulator: ASCII in, set-2 frames out on clock/data lines.
// Define PS2_TX_BREAK_EN to send make/F0/make per key; otherwise only the make code.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii,
  input  logic       valid,
  output logic       ready,
  output logic       err,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int unsigned BIT_TIME = 2 * CLK_DIV;
  localparam int unsigned DIV_W    = $clog2(BIT_TIME);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned BIT_W    = $clog2(FRAME_BITS);

  ps2_state_e            state_q, state_d;
  logic [7:0]            scan_q, scan_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  ps2_clk_q, ps2_clk_d;
  logic                  ps2_data_q, ps2_data_d;

  logic [7:0]            map_code;
  logic                  map_hit;

  ascii_to_scancode u_map (
    .ascii    (ascii),
    .scancode (map_code),
    .hit      (map_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      scan_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      frame_q    <= '1;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      scan_q     <= scan_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      frame_q    <= frame_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_d     = scan_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    div_d      = div_q;
    gap_d      = gap_q;
    frame_d    = frame_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (map_hit) begin
            scan_d     = map_code;
            byte_idx_d = 2'd0;
            state_d    = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        frame_d   = ps2_build_frame((byte_idx_q == 2'd1) ? BREAK_CODE : scan_q);
        bit_idx_d = '0;
        div_d     = '0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        if (div_q == DIV_W'(BIT_TIME - 1)) begin
          div_d = '0;
          if (bit_idx_q == BIT_W'(FRAME_BITS - 1)) begin
`ifdef PS2_TX_BREAK_EN
            if (byte_idx_q == 2'd2) begin
              state_d = IDLE;
            end else begin
              gap_d   = '0;
              state_d = GAP;
            end
`else
            gap_d   = '0;
            state_d = GAP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_d = '0;
`ifdef PS2_TX_BREAK_EN
          byte_idx_d = byte_idx_q + 2'd1;
          state_d    = LOAD;
`else
          state_d = IDLE;
`endif
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so the lines track the FSM exactly.
    ready_d    = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    ps2_clk_d  = !((state_d == SHIFT) && (div_d >= DIV_W'(CLK_DIV)));
    ps2_data_d = (state_d == SHIFT) ? frame_d[bit_idx_d] : 1'b1;
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: table vectors, hand corner cases, random keys.
module tb_ps2_keyboard_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 16;
`ifdef PS2_TX_BREAK_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ascii;
  logic       valid;
  logic       ready, err, busy, ps2_clk, ps2_data;

  ps2_keyboard_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .ascii    (ascii),
    .valid    (valid),
    .ready    (ready),
    .err      (err),
    .busy     (busy),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference key map, kept as plain lookup arrays.
  logic [7:0] letter_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                  8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                  8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                  8'h35, 8'h1A};
  logic [7:0] digit_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46};

  function automatic void model_map(input logic [7:0] c, output logic hit, output logic [7:0] code);
    hit  = 1'b1;
    code = 8'h00;
    if (c >= 8'h41 && c <= 8'h5A)      code = letter_tab[int'(c) - 8'h41];
    else if (c >= 8'h61 && c <= 8'h7A) code = letter_tab[int'(c) - 8'h61];
    else if (c >= 8'h30 && c <= 8'h39) code = digit_tab[int'(c) - 8'h30];
    else hit = 1'b0;
  endfunction

  logic       exp_clk [$];
  logic       exp_dat [$];
  logic [7:0] exp_bytes [$];

  task automatic push_n(input int n, input logic c, input logic d);
    for (int k = 0; k < n; k++) begin
      exp_clk.push_back(c);
      exp_dat.push_back(d);
    end
  endtask

  // Expected line levels per cycle after the accepting edge, while busy is high.
  task automatic build_expected(input logic [7:0] make);
    logic [7:0] b;
    logic       bitv;
    exp_clk.delete();
    exp_dat.delete();
    exp_bytes.delete();
    for (int n = 0; n < NBYTES; n++) begin
      b = (n == 1) ? 8'hF0 : make;
      exp_bytes.push_back(b);
      push_n(1, 1'b1, 1'b1);
      for (int k = 0; k < 11; k++) begin
        if (k == 0)      bitv = 1'b0;
        else if (k <= 8) bitv = b[k-1];
        else if (k == 9) bitv = ($countones(b) % 2 == 0);
        else             bitv = 1'b1;
        push_n(CLK_DIV, 1'b1, bitv);
        push_n(CLK_DIV, 1'b0, bitv);
      end
      if (NBYTES == 1 || n < NBYTES - 1) push_n(GAP_CYCLES, 1'b1, 1'b1);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", 32'(ready), 32'd1);
  endtask

  // Send one character from a negedge; returns at the negedge where ready is back.
  task automatic send_key(input logic [7:0] ch, input logic exp_hit, input logic [7:0] exp_code,
                          input int inject_at, input logic [7:0] inject_ch);
    int         len, mism, first_bad;
    logic       prev_clk;
    logic       rx_bits [$];
    logic [7:0] rx_byte;
    int         frame_errs, byte_errs;
    wait_ready();
    ascii = ch;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    if (!exp_hit) begin
      check($sformatf("err_pulse_%02h", ch), 32'(err), 32'd1);
      check($sformatf("unmapped_state_%02h", ch), 32'({busy, ready, ps2_clk, ps2_data}), 32'b0111);
      @(negedge clk);
      check($sformatf("err_drop_%02h", ch), 32'({err, busy, ready, ps2_clk, ps2_data}), 32'b00111);
      return;
    end
    build_expected(exp_code);
    len       = exp_clk.size();
    mism      = 0;
    first_bad = -1;
    prev_clk  = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == inject_at) begin
        ascii = inject_ch;
        valid = 1'b1;
      end else if (i == inject_at + 1) begin
        valid = 1'b0;
      end
      if ({ps2_clk, ps2_data, busy, ready, err} !== {exp_clk[i], exp_dat[i], 1'b1, 1'b0, 1'b0}) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
      if (prev_clk && !ps2_clk) rx_bits.push_back(ps2_data);
      prev_clk = ps2_clk;
      if (i < len - 1) @(negedge clk);
    end
    valid = 1'b0;
    if (mism != 0) $display("  key %02h: first waveform deviation at cycle %0d", ch, first_bad);
    check($sformatf("wave_mismatches_%02h", ch), 32'(mism), 32'd0);
    @(negedge clk);
    check($sformatf("busy_end_%02h", ch), 32'({busy, ready, ps2_clk, ps2_data}), 32'b0111);
    // Receiver view: decode bits sampled on falling clock edges.
    check($sformatf("rx_bitcount_%02h", ch), 32'(rx_bits.size()), 32'(NBYTES * 11));
    frame_errs = 0;
    byte_errs  = 0;
    for (int n = 0; n < NBYTES && (n * 11 + 10) < rx_bits.size(); n++) begin
      for (int k = 0; k < 8; k++) rx_byte[k] = rx_bits[n*11 + 1 + k];
      if (rx_bits[n*11] != 1'b0 || rx_bits[n*11 + 10] != 1'b1) frame_errs++;
      if (($countones(rx_byte) + int'(rx_bits[n*11 + 9])) % 2 != 1) frame_errs++;
      if (rx_byte != exp_bytes[n]) byte_errs++;
    end
    check($sformatf("rx_framing_%02h", ch), 32'(frame_errs), 32'd0);
    check($sformatf("rx_bytes_%02h", ch), 32'(byte_errs), 32'd0);
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       hit;
    logic [7:0] code;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [7:0] rc, rcode;
    logic       rhit;
    int         rst_at;

    vecs.push_back('{8'h41, 1'b1, 8'h1C});
    vecs.push_back('{8'h61, 1'b1, 8'h1C});
    vecs.push_back('{8'h31, 1'b1, 8'h16});
    vecs.push_back('{8'h21, 1'b0, 8'h00});
    vecs.push_back('{8'h5A, 1'b1, 8'h1A});
    vecs.push_back('{8'h71, 1'b1, 8'h15});
    vecs.push_back('{8'h30, 1'b1, 8'h45});
    vecs.push_back('{8'h39, 1'b1, 8'h46});
    vecs.push_back('{8'h40, 1'b0, 8'h00});
    vecs.push_back('{8'h5B, 1'b0, 8'h00});
    vecs.push_back('{8'h60, 1'b0, 8'h00});
    vecs.push_back('{8'h7B, 1'b0, 8'h00});
    vecs.push_back('{8'h2F, 1'b0, 8'h00});
    vecs.push_back('{8'h3A, 1'b0, 8'h00});

    rst   = 1'b1;
    valid = 1'b0;
    ascii = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({ready, err, busy, ps2_clk, ps2_data}), 32'b10011);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) send_key(vecs[i].ch, vecs[i].hit, vecs[i].code, -1, 8'h00);

    // Valid during a key is dropped; the same char presented when ready returns is taken.
    send_key(8'h41, 1'b1, 8'h1C, 100, 8'h42);
    send_key(8'h42, 1'b1, 8'h32, -1, 8'h00);

    // Reset in the middle of bit 5 of the second frame (or the only frame).
    rst_at = 1 + 5 * 2 * CLK_DIV + 2;
    if (NBYTES == 3) rst_at += 11 * 2 * CLK_DIV + GAP_CYCLES + 1;
    ascii = 8'h41;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (rst_at) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_lines", 32'({ps2_clk, ps2_data}), 32'b11);
    check("abort_ready_busy", 32'({ready, busy, err}), 32'b100);
    rst = 1'b0;
    @(negedge clk);
    send_key(8'h5A, 1'b1, 8'h1A, -1, 8'h00);

    for (int r = 0; r < 12; r++) begin
      rc = 8'($urandom_range(32'h20, 32'h7E));
      model_map(rc, rhit, rcode);
      send_key(rc, rhit, rcode, -1, 8'h00);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_tx.md
Name: ps2_keyboard_tx

Overview:
Device-side PS/2 keyboard emulator. It accepts one ASCII character per handshake, maps it to its set-2 scancode, and serialises the make code, 0xF0 and the make code again onto open-drain-style PS/2 clock/data outputs. Used as the stimulus source for the keyboard receive path: scancode decode, ASCII conversion and seven-segment display.

Parameters:
CLK_DIV, 4, system clocks per PS/2 clock half-period (>=2)
GAP_CYCLES, 16, idle system clocks (lines high) between consecutive bytes of one key (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
ascii  input  8  character to send
valid  input  1  ascii is valid this cycle
ready  output  1  block can accept a character
err  output  1  one-cycle pulse: accepted character has no scancode
busy  output  1  a key sequence is in progress
ps2_clk  output  1  PS/2 clock line (idle 1)
ps2_data  output  1  PS/2 data line (idle 1)

Behaviour:
- Reset: ready=1, err=0, busy=0, ps2_clk=1, ps2_data=1, FSM=IDLE, all counters 0. Reset mid-frame aborts at once; lines read 1/1 in the cycle after rst is sampled.
- Handshake: a character is accepted on a clk edge where valid&&ready. ready=!busy. valid while busy is ignored, not queued.
- Mapping (combinational, inverse of the receive table):
  - 'A'-'Z' (0x41-0x5A) and 'a'-'z' (0x61-0x7A) -> letter scancodes, e.g. A=1C, B=32, Z=1A, Q=15.
  - '0'-'9' -> 45,16,1E,26,25,2E,36,3D,3E,46.
  - Anything else is unmapped: err=1 for exactly one cycle after the accepting edge, no transmission, busy stays 0, ready stays 1.
- Byte sequence per key: [make], GAP, [F0], GAP, [make]; byte_idx counts 0..2.
- FSM states:
  - IDLE: accepts a mapped character, latches the scancode, byte_idx=0, goes to LOAD.
  - LOAD: one cycle; builds the 11-bit frame: start 0, d0..d7 LSB first, odd parity (bit = ~^data), stop 1. bit_idx=0. Goes to SHIFT.
  - SHIFT: each bit lasts 2*CLK_DIV cycles.
    - First CLK_DIV cycles: ps2_clk=1, ps2_data=bit.
    - Next CLK_DIV cycles: ps2_clk=0, data unchanged. The receiver samples on the ps2_clk falling edge.
    - After bit 10 finishes: if byte_idx==2, go to IDLE; else go to GAP.
  - GAP: lines 1/1 for GAP_CYCLES cycles, then byte_idx++, go to LOAD.
- ps2_data changes only while ps2_clk=1. Both outputs are registered.
- busy=1 from the cycle after acceptance until the cycle after the last stop-bit low phase ends, when it returns to IDLE.
- Frame length = 22*CLK_DIV cycles. Full key = 3 frames + 3 LOAD cycles + 2*GAP_CYCLES.
- Back-to-back: ready rises together with the return to IDLE. A new valid on that edge is accepted, so the minimum inter-key spacing is one idle cycle.

Optional Feature:
PS2_TX_BREAK_EN
- Defined: the full make/F0/make sequence as above.
- Undefined: only the make code is sent. After the frame the FSM goes straight to IDLE; GAP is used only between keys (GAP_CYCLES idle before ready rises). Key time = 1 frame + 1 + GAP_CYCLES.

Decomposition:
- Package ps2_pkg holds:
  - frame constants FRAME_BITS=11 and BREAK_CODE=8'hF0;
  - the FSM state enum (IDLE, LOAD, SHIFT, GAP);
  - a function that builds the frame from a data byte.
- One sub-module: ascii_to_scancode, a combinational table with outputs scancode[7:0] and hit. It is the inverse counterpart of the receive-side table.

Test Plan:
- CLK_DIV=4, GAP=16, ascii=0x41 held one cycle -> ready drops; first frame on ps2_data at falling edges = 0,0,0,1,1,1,0,0,0,0,1 (0x1C, parity 0); then F0 frame 0,0,0,0,0,1,1,1,1,1,1; then 0x1C again; busy low after 3*88+3+32 cycles.
- ascii=0x61 ('a') -> identical waveform to 0x41.
- ascii=0x31 ('1') -> make frame 0,0,1,1,0,1,0,0,0,0,1 (0x16, parity 0).
- ascii=0x21 ('!') -> err high exactly 1 cycle, ps2_clk/ps2_data stay 1, ready stays 1.
- valid with 0x42 pulsed during the 0x41 sequence -> ignored, no 0x32 frame; 0x42 presented at the ready rise -> accepted on that edge.
- rst asserted at bit 5 of the F0 frame -> next cycle ps2_clk=1, ps2_data=1, ready=1, busy=0; a following 0x5A sends a clean 0x1A sequence.
